priority_rotation_ctrl: RTL
===========================

Name: priority_rotation_ctrl

Overview:
- Sequential priority/in-service controller for the 8259 core.
- Holds the In-Service Register (ISR) and the lowest-priority pointer.
- Drives `rotate_amount` to the downstream rotator stage so the priority resolver can work on a rotated request vector.
- Runs the INTA acknowledge handshake, executes OCW2 EOI/rotation commands and raises `int_req` under fully-nested rules.

Parameters:
- None. The width is fixed at 8 interrupt levels; level numbers are 3 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- irr_in  input  8  masked pending requests (bit n = IRn)
- aeoi  input  1  auto-EOI mode, from ICW4
- inta_first  input  1  one-cycle pulse, first INTA of the acknowledge sequence
- inta_last  input  1  one-cycle pulse, final INTA of the acknowledge sequence
- ocw2_valid  input  1  one-cycle strobe, OCW2 written
- ocw2_cmd  input  3  {R, SL, EOI}
- ocw2_level  input  3  L2..L0 level field
- int_req  output  1  registered interrupt request to the CPU
- isr  output  8  in-service register
- ack_level  output  3  level acknowledged at the last inta_first
- spurious  output  1  last acknowledge found no winner
- rotate_amount  output  3  current lowest-priority level

Behaviour:
- **Reset (async, immediate):**
  - isr = 0, lowest = 7 (`rotate_amount` = 7, so IR0 is highest and IR7 lowest).
  - int_req = 0, ack_level = 7, spurious = 0.
  - Internal rotate_aeoi flag = 0.
  - Reset mid-handshake discards all acknowledge state.
- **Priority order:** levels rank from lowest+1 (highest) upward mod 8 to lowest (lowest priority). Wrap-around is required. Example: lowest = 4 gives order 5,6,7,0,1,2,3,4.
- **Winner:** the highest-priority set bit of irr_in.
- **Top-in-service:** the highest-priority set bit of isr.
- **int_req:**
  - Registered, recomputed every cycle, so it lags irr_in/isr changes by 1 cycle.
  - Asserts when a winner exists and either isr = 0 or the winner strictly outranks top-in-service.
  - A request at the same level as, or below, top-in-service does not assert it.
- **inta_first:**
  - If a winner exists (using pre-edge priority): set isr[winner], ack_level = winner, spurious = 0.
  - If no winner: ack_level = 7, spurious = 1, isr unchanged.
- **inta_last:**
  - If aeoi = 1 and spurious = 0: clear isr[ack_level].
  - If additionally rotate_aeoi = 1: lowest = ack_level.
  - If aeoi = 0: no action.
- **OCW2 commands** (on ocw2_valid; cmd = R,SL,EOI):
  - 001 non-specific EOI: clear top-in-service bit.
  - 011 specific EOI: clear isr[ocw2_level].
  - 101 rotate on non-specific EOI: clear top-in-service bit; lowest = that level.
  - 111 rotate on specific EOI: clear isr[ocw2_level]; lowest = ocw2_level.
  - 110 set priority: lowest = ocw2_level; isr unchanged.
  - 100 set rotate_aeoi = 1; 000 clear rotate_aeoi = 0.
  - 010 no operation.
  - Non-specific EOI (001/101) with isr = 0: nothing cleared, no rotation.
  - Specific EOI on a bit that is already clear: isr unchanged, but the rotation of 111 still applies.
- **Simultaneous events in one cycle** (all decisions use pre-edge state):
  - Clears from OCW2 and inta_last apply first, then the set from inta_first. If set and clear hit the same bit, set wins.
  - inta_first and OCW2 in the same cycle: the winner is chosen using the old lowest; a new lowest takes effect next cycle.
  - OCW2 rotation and AEOI rotation in the same cycle: OCW2 wins.
  - inta_first and inta_last asserted together: treated as inta_first followed by inta_last in the same cycle, so AEOI clears the newly set bit (isr nets unchanged).
- **rotate_amount:** equals lowest, registered, with no extra latency.

Test Plan:
1. **Reset / basic ack:**
   - Stimulus: after reset, irr_in = 0x24.
   - Required: int_req = 1 one cycle later. inta_first gives ack_level = 2, isr = 0x04, int_req = 0 next cycle (IR5 ranks below IR2).
2. **Nesting:**
   - Stimulus: isr = 0x20, irr_in = 0x08.
   - Required: int_req = 1, and inta_first gives isr = 0x28.
   - Then cmd 001 clears bit 3, giving isr = 0x20.
   - Then a second cmd 001 clears bit 5, giving isr = 0.
3. **Rotation wrap:**
   - Stimulus: cmd 110 with level 4, then irr_in = 0x11.
   - Required: rotate_amount = 4 and inta_first gives ack_level = 0 (IR0 outranks IR4 lowest).
   - Then cmd 111 with level 0: isr = 0, rotate_amount = 0.
   - Then irr_in = 0x03 with inta_first: ack_level = 1.
4. **AEOI with rotate:**
   - Stimulus: aeoi = 1, cmd 100, irr_in = 0x40, then inta_first and inta_last.
   - Required: isr goes 0x40 then 0x00, and rotate_amount = 6.
5. **Spurious:**
   - Stimulus: irr_in = 0 with inta_first.
   - Required: spurious = 1, ack_level = 7, isr unchanged.
   - A following inta_last with aeoi = 1 leaves isr unchanged.
6. **Collisions / reset:**
   - Stimulus: isr = 0x02, cmd 011 with level 1 in the same cycle as inta_first with irr_in = 0x02.
   - Required: isr = 0x02 (set wins).
   - Then asserting reset mid-cycle: all outputs return to reset values immediately.

Source files
------------

// File: rtl/priority_rotation_ctrl.sv
// 8259 priority/in-service controller: ISR, rotating lowest-priority pointer, INTA and OCW2 handling.
// int_req registered (1-cycle lag); all other state updates on the edge after the triggering strobe.
module priority_rotation_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr_in,
    input  logic       aeoi,
    input  logic       inta_first,
    input  logic       inta_last,
    input  logic       ocw2_valid,
    input  logic [2:0] ocw2_cmd,
    input  logic [2:0] ocw2_level,
    output logic       int_req,
    output logic [7:0] isr,
    output logic [2:0] ack_level,
    output logic       spurious,
    output logic [2:0] rotate_amount
);

    logic [7:0] isr_q, isr_d;
    logic [2:0] lowest_q, lowest_d;
    logic [2:0] ack_q, ack_d;
    logic       int_req_q, int_req_d;
    logic       spur_q, spur_d;
    logic       rot_aeoi_q, rot_aeoi_d;

    // Returns {found, level}; scans from lowest priority up so the highest-priority hit is written last.
    function automatic logic [3:0] pick_top(input logic [7:0] vec, input logic [2:0] low);
        logic [3:0] r;
        logic [2:0] lvl;
        r = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            lvl = low + 3'(k);
            if (vec[lvl]) r = {1'b1, lvl};
        end
        return r;
    endfunction

    logic [3:0] win, top;
    logic [2:0] win_rank, top_rank;
    logic [2:0] eff_ack;
    logic       eff_spur;
    logic       ocw_rot;

    always_comb begin
        win        = pick_top(irr_in, lowest_q);
        top        = pick_top(isr_q, lowest_q);
        win_rank   = win[2:0] - lowest_q - 3'd1;
        top_rank   = top[2:0] - lowest_q - 3'd1;

        int_req_d  = win[3] && ((isr_q == 8'h00) || (win_rank < top_rank));
        isr_d      = isr_q;
        lowest_d   = lowest_q;
        rot_aeoi_d = rot_aeoi_q;
        ack_d      = ack_q;
        spur_d     = spur_q;
        ocw_rot    = 1'b0;

        if (ocw2_valid) begin
            unique case (ocw2_cmd)
                3'b001: if (top[3]) isr_d[top[2:0]] = 1'b0;
                3'b011: isr_d[ocw2_level] = 1'b0;
                3'b101: if (top[3]) begin
                    isr_d[top[2:0]] = 1'b0;
                    lowest_d        = top[2:0];
                    ocw_rot         = 1'b1;
                end
                3'b111: begin
                    isr_d[ocw2_level] = 1'b0;
                    lowest_d          = ocw2_level;
                    ocw_rot           = 1'b1;
                end
                3'b110: begin
                    lowest_d = ocw2_level;
                    ocw_rot  = 1'b1;
                end
                3'b100:  rot_aeoi_d = 1'b1;
                3'b000:  rot_aeoi_d = 1'b0;
                default: ;
            endcase
        end

        // Set follows the OCW2 clear so a same-bit collision leaves the bit set.
        if (inta_first) begin
            if (win[3]) begin
                isr_d[win[2:0]] = 1'b1;
                ack_d           = win[2:0];
                spur_d          = 1'b0;
            end else begin
                ack_d  = 3'd7;
                spur_d = 1'b1;
            end
        end

        // A combined first/last acknowledge sees this cycle's ack result.
        eff_ack  = ack_d;
        eff_spur = spur_d;
        if (inta_last && aeoi && !eff_spur) begin
            isr_d[eff_ack] = 1'b0;
            if (rot_aeoi_q && !ocw_rot) lowest_d = eff_ack;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isr_q      <= 8'h00;
            lowest_q   <= 3'd7;
            ack_q      <= 3'd7;
            int_req_q  <= 1'b0;
            spur_q     <= 1'b0;
            rot_aeoi_q <= 1'b0;
        end else begin
            isr_q      <= isr_d;
            lowest_q   <= lowest_d;
            ack_q      <= ack_d;
            int_req_q  <= int_req_d;
            spur_q     <= spur_d;
            rot_aeoi_q <= rot_aeoi_d;
        end
    end

    assign int_req       = int_req_q;
    assign isr           = isr_q;
    assign ack_level     = ack_q;
    assign spurious      = spur_q;
    assign rotate_amount = lowest_q;

endmodule
